apb_requester: RTL and testbench
================================

APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 Parameter: ADDR_W, 32, APB address width.
REQ-002 Parameter: DATA_W, 32, APB data width.
REQ-003 Parameter: TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort (range 2..255).
REQ-004 PCLK  input  1  single clock; all state changes on rising edge.
REQ-005 PRESET  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command FIFO not full.
REQ-008 cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-009 cmd_addr  input  ADDR_W  target register address.
REQ-010 cmd_wdata  input  DATA_W  write data; ignored for reads.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  transfer aborted by timeout; qualified by rsp_valid.
REQ-014 PSEL  output  1  APB select.
REQ-015 PENABLE  output  1  APB access phase.
REQ-016 PWRITE  output  1  APB direction.
REQ-017 PADDR  output  ADDR_W  APB address.
REQ-018 PWDATA  output  DATA_W  APB write data.
REQ-019 PRDATA  input  DATA_W  APB read data from completer.
REQ-020 PREADY  input  1  completer ready.

Function
REQ-021 Command buffering: 2-entry FIFO; push on cmd_valid && cmd_ready; cmd_ready = !full (registered-state based, no combinational path from pop).
REQ-022 Push while full is impossible; push and pop in the same cycle with 1 entry leaves count at 1.
REQ-023 FSM states: IDLE, SETUP, ACCESS.
REQ-024 IDLE: PSEL=0, PENABLE=0; go to SETUP when FIFO non-empty.
REQ-025 SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from FIFO head; always go to ACCESS.
REQ-026 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable; remain until PREADY=1 or timeout.
REQ-027 On PREADY=1 in ACCESS: pop FIFO; next cycle rsp_valid=1, rsp_err=0, rsp_rdata=PRDATA sampled in that edge (reads) or 0 (writes).
REQ-028 After completion: next state SETUP if FIFO still non-empty after pop (no IDLE gap), else IDLE.
REQ-029 Timeout: counter cleared on SETUP entry, increments each ACCESS cycle with PREADY=0; on reaching TIMEOUT, pop, go IDLE or SETUP per REQ-028, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-030 PREADY=1 in the same cycle the counter reaches TIMEOUT counts as success (PREADY wins).
REQ-031 PREADY and PRDATA ignored outside ACCESS.
REQ-032 Latency: command accepted at edge N into empty FIFO while IDLE -> SETUP from N+1, ACCESS from N+2, with PREADY=1 at N+2 rsp_valid at N+3.
REQ-033 P* outputs and rsp_* registered; unused PWDATA driven 0 on reads and in IDLE.

Reset
REQ-034 PRESET asserted: immediately PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FIFO emptied, counter=0, FSM=IDLE.
REQ-035 Reset mid-transfer aborts it silently: no rsp_valid for the in-flight or buffered commands.
REQ-036 cmd_ready=0 during reset, 1 from the first edge after release.

Structure
REQ-037 Shared package apb_pkg: FSM state enum (IDLE/SETUP/ACCESS) and command struct {write, addr, wdata}.
REQ-038 One sub-module: apb_cmd_fifo (2-entry, parameterised width, async active-high reset).

Verification
REQ-039 Write 0x0 <- 0x00000005, PREADY tied 1 -> SETUP 1 cycle, ACCESS 1 cycle, PWDATA=5 stable, rsp_valid one cycle, rsp_err=0, rsp_rdata=0.
REQ-040 Read 0x8, PREADY low 3 ACCESS cycles then high with PRDATA=0x0000000D -> PADDR held 4 ACCESS cycles, rsp_rdata=0xD.
REQ-041 Three back-to-back commands (write 0x0, write 0x4, read 0x8) -> cmd_ready drops when 2 buffered, transfers contiguous SETUP/ACCESS with no IDLE cycle, 3 rsp pulses in order.
REQ-042 Read 0xC, PREADY never asserted, TIMEOUT=16 -> exactly 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL drops.
REQ-043 PRESET asserted during ACCESS with 1 command buffered -> P* outputs 0 asynchronously, no rsp_valid afterwards, FSM IDLE.
REQ-044 PREADY=1 on the 16th ACCESS cycle -> success response, rsp_err=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states and the buffered command.
// Command fields are sized for the widest address/data the requester carries.
package apb_pkg;

   localparam int APB_AW = 32;
   localparam int APB_DW = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   typedef struct packed {
      logic              write;
      logic [APB_AW-1:0] addr;
      logic [APB_DW-1:0] wdata;
   } apb_cmd_t;

   localparam int CMD_W = $bits(apb_cmd_t);

   // Reads carry zero write data so PWDATA is 0 for them downstream
   function automatic apb_cmd_t apb_mk_cmd(
      input logic              w,
      input logic [APB_AW-1:0] a,
      input logic [APB_DW-1:0] d
   );
      apb_cmd_t c;
      c.write = w;
      c.addr  = a;
      c.wdata = w ? d : '0;
      return c;
   endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Two-entry command FIFO; also exposes the entry that becomes head after a pop.
module apb_cmd_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic         o_ready,
   output logic         o_empty,
   output logic         o_more,
   output logic [W-1:0] o_head,
   output logic [W-1:0] o_next
);

   logic [W-1:0] r_mem [2];
   logic [1:0]   r_count;
   logic         r_rd;
   logic         r_wr;
   logic         r_live;
   logic         w_push;
   logic         w_pop;

   assign o_ready = r_live && (r_count != 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign w_push  = i_push && o_ready;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rd];

   // After a pop the head is the second entry, or the word arriving now
   assign o_next = (r_count == 2'd2) ? r_mem[~r_rd] : i_data;
   assign o_more = (r_count == 2'd2) || w_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 2'd0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_live  <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_push) r_wr <= ~r_wr;
         if (w_pop) r_rd <= ~r_rd;
         r_count <= r_count
                  + {1'b0, w_push}
                  - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/apb_requester.sv
// APB requester: runs buffered commands as SETUP/ACCESS transfers and
// aborts any transfer whose ACCESS phase outlasts TIMEOUT cycles.
module apb_requester
   import apb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   apb_state_t        r_state;
   apb_state_t        w_state_nxt;
   logic [7:0]        r_cnt;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic              r_rsp_valid;
   logic              r_rsp_err;
   logic [DATA_W-1:0] r_rsp_rdata;

   apb_cmd_t          w_cmd_in;
   apb_cmd_t          w_head;
   apb_cmd_t          w_next;
   apb_cmd_t          w_sel;
   logic              w_empty;
   logic              w_more;
   logic              w_pop;
   logic              w_ok;
   logic              w_err;
   logic              w_load;
   logic              w_tmo;

   assign w_cmd_in = apb_mk_cmd(cmd_write,
                                APB_AW'(cmd_addr),
                                APB_DW'(cmd_wdata));

   apb_cmd_fifo #(
      .W (CMD_W)
   ) u_fifo (
      .clk     (PCLK),
      .rst     (PRESET),
      .i_push  (cmd_valid),
      .i_data  (w_cmd_in),
      .i_pop   (w_pop),
      .o_ready (cmd_ready),
      .o_empty (w_empty),
      .o_more  (w_more),
      .o_head  (w_head),
      .o_next  (w_next)
   );

   assign w_tmo = (r_cnt == TMO_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_ok        = 1'b0;
      w_err       = 1'b0;
      w_load      = 1'b0;
      w_sel       = w_head;
      unique case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_state_nxt = SETUP;
               w_load      = 1'b1;
            end
         end
         SETUP: begin
            w_state_nxt = ACCESS;
         end
         ACCESS: begin
            // PREADY wins over a timeout landing in the same cycle
            if (PREADY || w_tmo) begin
               w_pop = 1'b1;
               w_ok  = PREADY;
               w_err = !PREADY;
               if (w_more) begin
                  w_state_nxt = SETUP;
                  w_load      = 1'b1;
                  w_sel       = w_next;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state     <= IDLE;
         r_cnt       <= 8'd0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_psel    <= (w_state_nxt != IDLE);
         r_penable <= (w_state_nxt == ACCESS);
         if (w_load) begin
            r_pwrite <= w_sel.write;
            r_paddr  <= w_sel.addr[ADDR_W-1:0];
            r_pwdata <= w_sel.wdata[DATA_W-1:0];
         end else if (w_state_nxt == IDLE) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
         end
         if (w_load) begin
            r_cnt <= 8'd0;
         end else if (r_state == ACCESS && !PREADY) begin
            r_cnt <= r_cnt + 8'd1;
         end
         r_rsp_valid <= w_ok || w_err;
         r_rsp_err   <= w_err;
         r_rsp_rdata <= (w_ok && !r_pwrite) ? PRDATA : '0;
      end
   end

   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_pwrite;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: reactive APB completer plus a transaction-level
// scoreboard of accepted commands and their expected responses.
module tb_apb_requester;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY;

   apb_requester #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TMO)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cmd_t;

   cmd_t          q_gen[$];
   cmd_t          q_cmd[$];
   int            q_wait[$];
   logic [DW-1:0] q_prd[$];
   cmd_t          drv;

   int            n_chk = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            acc_n = 0;
   int            cur_wait = 0;
   int            idle_acc = -1;
   int            n_rsp = 0;
   logic [DW-1:0] cur_prd = '0;
   bit            prev_setup = 1'b0;
   bit            prev_psel = 1'b0;
   bit            rdy_drv = 1'b0;
   bit            gaps = 1'b0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic add(input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int wt,
                      input logic [DW-1:0] prd);
      cmd_t c;
      c.w = w;
      c.a = a;
      c.d = d;
      q_gen.push_back(c);
      q_wait.push_back(wt);
      q_prd.push_back(prd);
   endtask

   function automatic int rnd_wait();
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) return TMO - 1;
      if (r == 1) return TMO;
      if (r == 2) return int'($urandom_range(17, 40));
      return int'($urandom_range(0, 4));
   endfunction

   task automatic step();
      cmd_t          c;
      bit            e_err;
      logic [DW-1:0] e_wd;
      @(negedge PCLK);
      cyc++;
      if (cmd_valid && rdy_drv) begin
         if (q_cmd.size() == 0 && !prev_psel) idle_acc = cyc;
         q_cmd.push_back(drv);
         c = q_gen.pop_front();
      end
      if (rsp_valid) begin
         if (q_cmd.size() == 0) begin
            chk("rsp_spurious", rsp_valid, 1'b0);
         end else begin
            c = q_cmd.pop_front();
            e_err = (cur_wait >= TMO);
            chk("rsp_err", rsp_err, e_err);
            chk("rsp_rdata", rsp_rdata,
                (e_err || c.w) ? {DW{1'b0}} : cur_prd);
            chk("acc_cycles", acc_n, e_err ? TMO : cur_wait + 1);
            chk("next_psel", PSEL, q_cmd.size() != 0);
            chk("next_penable", PENABLE, 1'b0);
            n_rsp++;
            acc_n = 0;
         end
      end
      chk("cmd_ready", cmd_ready, q_cmd.size() < 2);
      if (prev_setup) chk("setup_to_access", {PSEL, PENABLE}, 2'b11);
      if (PSEL) begin
         if (q_cmd.size() == 0) begin
            chk("psel_noreq", PSEL, 1'b0);
         end else begin
            e_wd = q_cmd[0].w ? q_cmd[0].d : {DW{1'b0}};
            chk("paddr", PADDR, q_cmd[0].a);
            chk("pwrite", PWRITE, q_cmd[0].w);
            chk("pwdata", PWDATA, e_wd);
         end
         if (!PENABLE && idle_acc >= 0) begin
            chk("lat_setup", cyc - idle_acc, 1);
            idle_acc = -1;
         end
         if (PENABLE) begin
            acc_n++;
            if (acc_n == 1) begin
               if (q_wait.size() != 0) cur_wait = q_wait.pop_front();
               else cur_wait = 0;
               if (q_prd.size() != 0) cur_prd = q_prd.pop_front();
               else cur_prd = $urandom;
            end
            chk("acc_bound", acc_n > TMO, 1'b0);
         end
      end else begin
         chk("idle_penable", PENABLE, 1'b0);
         chk("idle_pwdata", PWDATA, {DW{1'b0}});
      end
      prev_setup = PSEL && !PENABLE;
      prev_psel  = PSEL;
      if (PSEL && PENABLE) begin
         PREADY = (acc_n > cur_wait);
         PRDATA = PREADY ? cur_prd : $urandom;
      end else begin
         PREADY = 1'($urandom_range(0, 1));
         PRDATA = $urandom;
      end
      rdy_drv = cmd_ready;
      if (q_gen.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
         drv       = q_gen[0];
         cmd_valid = 1'b1;
         cmd_write = drv.w;
         cmd_addr  = drv.a;
         cmd_wdata = drv.d;
      end else begin
         cmd_valid = 1'b0;
         cmd_write = 1'($urandom_range(0, 1));
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
      end
   endtask

   task automatic drain(input int max);
      int k;
      k = 0;
      while ((q_gen.size() != 0 || q_cmd.size() != 0 || PSEL)
             && k < max) begin
         step();
         k++;
      end
      chk("drain", q_gen.size() + q_cmd.size(), 0);
      repeat (2) step();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int base;
      PRESET    = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      PRDATA    = '0;
      PREADY    = 1'b0;
      #1 PRESET = 1'b1;
      #1;
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_penable", PENABLE, 1'b0);
      chk("rst_pwrite", PWRITE, 1'b0);
      chk("rst_paddr", PADDR, {AW{1'b0}});
      chk("rst_pwdata", PWDATA, {DW{1'b0}});
      chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
      chk("rst_rdata", rsp_rdata, {DW{1'b0}});
      repeat (2) @(negedge PCLK);
      chk("rst_ready", cmd_ready, 1'b0);
      PRESET = 1'b0;

      add(1'b1, 32'h0, 32'h5, 0, 32'h0);
      drain(40);

      add(1'b0, 32'h8, 32'h0, 3, 32'hD);
      drain(40);

      base = n_rsp;
      add(1'b1, 32'h0, 32'h11, 0, 32'h0);
      add(1'b1, 32'h4, 32'h22, 0, 32'h0);
      add(1'b0, 32'h8, 32'h0, 0, 32'h5A5A_0033);
      drain(60);
      chk("b2b_rsps", n_rsp - base, 3);

      add(1'b0, 32'hC, 32'h0, 255, 32'h0);
      drain(60);

      add(1'b0, 32'h8, 32'h0, TMO - 1, 32'hABCD_1234);
      add(1'b1, 32'h4, 32'h77, TMO - 1, 32'h0);
      drain(80);

      add(1'b1, 32'h10, 32'h99, 40, 32'h0);
      add(1'b0, 32'h14, 32'h0, 40, 32'h0);
      k = 0;
      while (!(PSEL && PENABLE && q_cmd.size() == 2) && k < 30) begin
         step();
         k++;
      end
      chk("rst_reach", PSEL && PENABLE && q_cmd.size() == 2, 1'b1);
      #2 PRESET = 1'b1;
      #1;
      chk("arst_psel", {PSEL, PENABLE, PWRITE}, 3'b000);
      chk("arst_paddr", PADDR, {AW{1'b0}});
      chk("arst_pwdata", PWDATA, {DW{1'b0}});
      chk("arst_rsp", {rsp_valid, rsp_err}, 2'b00);
      chk("arst_ready", cmd_ready, 1'b0);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("arst_hold_ready", cmd_ready, 1'b0);
      chk("arst_hold_rsp", rsp_valid, 1'b0);
      PRESET = 1'b0;
      q_gen.delete();
      q_cmd.delete();
      q_wait.delete();
      q_prd.delete();
      acc_n      = 0;
      idle_acc   = -1;
      prev_setup = 1'b0;
      prev_psel  = 1'b0;
      rdy_drv    = 1'b0;
      repeat (20) step();

      gaps = 1'b1;
      for (int i = 0; i < 150; i++) begin
         add(1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 1023)) << 2,
             $urandom, rnd_wait(), $urandom);
      end
      drain(6000);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
